ep16_ram_port: RTL and testbench
================================

# ep16_ram_port

CPU-side access port for the eP16 16-bit on-chip RAM. It converts the core's held-request/one-cycle-acknowledge memory handshake into the single-port RAM's Avalon-style control signals and accounts for the RAM's one-cycle synchronous read. It also captures read data, gates the RAM clock enable during pipeline hold, and rejects out-of-range addresses. It sits directly upstream of the RAM, between the eP16 core and the RAM slave.

## Interface
Parameters:
- ADDR_W, 11: RAM word-address width.
- DEPTH, 2048: number of implemented RAM words. Word addresses >= DEPTH are out of range.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W (ADDR_W+1 with byte mode)  word address, or byte address when byte mode is compiled in.
- cpu_size  in  1  0 = word, 1 = byte; ignored without byte mode.
- cpu_wdata  in  16  write data.
- cpu_hold  in  1  freezes the port and the RAM.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data; valid while cpu_ack is high and held afterwards.
- cpu_err  out  1  pulses with cpu_ack when the address was out of range.
- ram_address  out  ADDR_W  RAM address.
- ram_byteenable  out  2  lane enables.
- ram_chipselect  out  1  RAM chip select.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  16  RAM write data.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  16  unregistered RAM output, valid one edge after the address is sampled.

## Operation
- State machine states: IDLE, ISSUE, RD_WAIT, ACK.
- IDLE:
  - cpu_req=1 and address in range: register address, lanes, data and we into the ram_* outputs, then go to ISSUE.
  - cpu_req=1 and address out of range: go to ACK with cpu_err=1 and cpu_rdata=0. No RAM access is made.
- ISSUE: ram_chipselect=1, and ram_write=cpu_we as latched.
  - Write: go to ACK.
  - Read: go to RD_WAIT.
- RD_WAIT: chipselect drops, and ram_readdata is latched into cpu_rdata at the closing edge. Then go to ACK.
- ACK: cpu_ack=1 for exactly one cycle, then go to IDLE. cpu_req is not sampled in ACK, so a request still held high there is never accepted twice.
- Requests arriving while not in IDLE are ignored until the FSM returns to IDLE.
- cpu_hold=1:
  - ram_clken=0.
  - All registers and the FSM state hold, including a pending ACK; the pulse is delivered after the hold ends.
  - Otherwise ram_clken=1.
- Reset:
  - Priority over hold.
  - Mid-operation reset abandons the access: no ack is issued.
  - A write already in ISSUE may or may not land.
- Reset values: state IDLE; cpu_ack=0; cpu_err=0; cpu_rdata=0; ram_address=0; ram_byteenable=2'b11; ram_chipselect=0; ram_write=0; ram_writedata=0; ram_clken=1.
- ram_write is asserted only in ISSUE. ram_chipselect is 0 in IDLE, RD_WAIT and ACK.

## Timing
- Cycle 0 is the cycle in which cpu_req is sampled in IDLE.
- Write: ram_write high in cycle 1; cpu_ack high in cycle 2.
- Read: address presented in cycle 1; RAM samples it at the end of cycle 1; data is captured at the end of cycle 2; cpu_ack and cpu_rdata appear in cycle 3.
- Out-of-range access: cpu_ack and cpu_err appear in cycle 1.
- Minimum request spacing: a new request is accepted one cycle after ACK. This gives one write per 3 cycles and one read per 4 cycles.
- Each hold cycle adds exactly one cycle to the latency.

## Configuration
- EP16_RAM_PORT_BYTE_EN defined (byte mode):
  - cpu_addr is ADDR_W+1 bits. Bit 0 selects the lane: 0 = [7:0], 1 = [15:8]. Bits [ADDR_W:1] form the word address.
  - cpu_size=1 write: cpu_wdata[7:0] is replicated to both lanes; byteenable is 2'b01 or 2'b10.
  - cpu_size=1 read: the selected lane is returned zero-extended in cpu_rdata[7:0].
  - cpu_size=0: bit 0 is ignored and both lanes are used.
- Macro undefined:
  - cpu_addr is the word address.
  - cpu_size is ignored.
  - ram_byteenable is always 2'b11.

## Test plan
- Write 16'hA55A to word 5, then read word 5:
  - write cpu_ack in cycle 2;
  - read cpu_ack in cycle 3 with cpu_rdata=16'hA55A;
  - cpu_err=0 for both.
- Read word 2048 with DEPTH=2048: cpu_ack and cpu_err in cycle 1, cpu_rdata=0, ram_chipselect never high.
- Assert cpu_hold for 2 cycles during RD_WAIT:
  - ram_clken=0 during the hold;
  - cpu_ack arrives in cycle 5 with the correct data.
- Keep cpu_req high through ACK, then drop it: exactly one RAM access and one ack.
- Assert reset in ISSUE of a read: no ack, all outputs at their reset values the next cycle, and the next request is served normally.
- Byte mode (EP16_RAM_PORT_BYTE_EN):
  - write byte 8'h3C at byte address 11: ram_byteenable=2'b10;
  - a word read of word 5 then returns 16'h3C5A when the word held 16'hA55A;
  - a byte read at byte address 11 returns 16'h003C.

Source files
------------

// File: rtl/ep16_ram_port_if.sv
// ep16_ram_port_if: eP16 core memory handshake plus single-port RAM control bundle; cpu_addr widens by one bit under EP16_RAM_PORT_BYTE_EN.
interface ep16_ram_port_if #(parameter int ADDR_W = 11) ();
`ifdef EP16_RAM_PORT_BYTE_EN
  localparam int CPU_AW = ADDR_W + 1;
`else
  localparam int CPU_AW = ADDR_W;
`endif
  logic cpu_req;
  logic cpu_we;
  logic [CPU_AW-1:0] cpu_addr;
  logic cpu_size;
  logic [15:0] cpu_wdata;
  logic cpu_hold;
  logic cpu_ack;
  logic [15:0] cpu_rdata;
  logic cpu_err;
  logic [ADDR_W-1:0] ram_address;
  logic [1:0] ram_byteenable;
  logic ram_chipselect;
  logic ram_write;
  logic [15:0] ram_writedata;
  logic ram_clken;
  logic [15:0] ram_readdata;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata, cpu_hold, ram_readdata,
    output cpu_ack, cpu_rdata, cpu_err, ram_address, ram_byteenable, ram_chipselect,
    ram_write, ram_writedata, ram_clken
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata, cpu_hold, ram_readdata,
    input cpu_ack, cpu_rdata, cpu_err, ram_address, ram_byteenable, ram_chipselect,
    ram_write, ram_writedata, ram_clken
  );
endinterface

// File: rtl/ep16_ram_port.sv
// ep16_ram_port: eP16 CPU-to-RAM access port with one-cycle read accounting, hold gating and range check.
// Byte-lane access is compiled in with EP16_RAM_PORT_BYTE_EN.
module ep16_ram_port #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input logic clk,
  input logic reset,
  ep16_ram_port_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RD_WAIT = 2'd2, ACK = 2'd3;
  logic [1:0] state;
  logic we, err, byte_rd, lane, in_range;
  logic [ADDR_W-1:0] waddr;
  logic [1:0] be;
  logic [15:0] wd, rdata_n;
`ifdef EP16_RAM_PORT_BYTE_EN
  assign waddr = bus.cpu_addr[ADDR_W:1];
  assign be = bus.cpu_size ? (bus.cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign wd = bus.cpu_size ? {2{bus.cpu_wdata[7:0]}} : bus.cpu_wdata;
  assign rdata_n = byte_rd ? {8'h00, lane ? bus.ram_readdata[15:8] : bus.ram_readdata[7:0]} : bus.ram_readdata;
`else
  logic unused;
  assign unused = bus.cpu_size ^ byte_rd ^ lane;
  assign waddr = bus.cpu_addr;
  assign be = 2'b11;
  assign wd = bus.cpu_wdata;
  assign rdata_n = bus.ram_readdata;
`endif
  assign in_range = 32'(waddr) < DEPTH;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      we <= 1'b0;
      err <= 1'b0;
      byte_rd <= 1'b0;
      lane <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ram_address <= '0;
      bus.ram_byteenable <= 2'b11;
      bus.ram_writedata <= '0;
    end else if (!bus.cpu_hold) begin
      case (state)
        IDLE: if (bus.cpu_req) begin
          if (in_range) begin
            bus.ram_address <= waddr;
            bus.ram_byteenable <= be;
            bus.ram_writedata <= wd;
            we <= bus.cpu_we;
            byte_rd <= bus.cpu_size;
            lane <= bus.cpu_addr[0];
            err <= 1'b0;
            state <= ISSUE;
          end else begin
            err <= 1'b1;
            bus.cpu_rdata <= '0;
            state <= ACK;
          end
        end
        ISSUE: state <= we ? ACK : RD_WAIT;
        RD_WAIT: begin
          bus.cpu_rdata <= rdata_n;
          state <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // a held ACK stays pending and pulses once the hold lifts
  assign bus.cpu_ack = state == ACK && !bus.cpu_hold;
  assign bus.cpu_err = bus.cpu_ack && err;
  assign bus.ram_chipselect = state == ISSUE;
  assign bus.ram_write = state == ISSUE && we;
  assign bus.ram_clken = !bus.cpu_hold || reset;
endmodule

// File: tb/tb_ep16_ram_port.sv
// tb_ep16_ram_port: directed self-checking bench for ep16_ram_port with a behavioural RAM.
module tb_ep16_ram_port;
  localparam int AW = 12;
`ifdef EP16_RAM_PORT_BYTE_EN
  localparam int CAW = AW + 1;
`else
  localparam int CAW = AW;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ep16_ram_port_if #(.ADDR_W(AW)) bus ();
  ep16_ram_port #(.ADDR_W(AW), .DEPTH(2048)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rd_q = '0;
  always @(posedge clk)
    if (bus.ram_clken && bus.ram_chipselect) begin
      if (bus.ram_write) begin
        if (bus.ram_byteenable[0]) mem[bus.ram_address][7:0] <= bus.ram_writedata[7:0];
        if (bus.ram_byteenable[1]) mem[bus.ram_address][15:8] <= bus.ram_writedata[15:8];
      end else rd_q <= mem[bus.ram_address];
    end
  assign bus.ram_readdata = rd_q;
  function automatic logic [CAW-1:0] wa(input int w);
`ifdef EP16_RAM_PORT_BYTE_EN
    return CAW'(w << 1);
`else
    return CAW'(w);
`endif
  endfunction
  task automatic do_access(input logic we, input logic [CAW-1:0] a, input logic sz, input logic [15:0] wd,
                           input int hs, input int hl, input logic keep,
                           output int lat, output int acks, output logic [15:0] rd, output logic e,
                           output int acc, output int clk_low, output int wr_at, output logic [1:0] be_seen);
    logic drop;
    lat = -1; acks = 0; rd = '0; e = 1'b0; acc = 0; clk_low = 0; wr_at = -1; be_seen = 2'b00; drop = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_size = sz; bus.cpu_wdata = wd; bus.cpu_hold = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (drop) bus.cpu_req = 1'b0;
      drop = 1'b0;
      bus.cpu_hold = (n >= hs && n < hs + hl);
      @(negedge clk);
      if (!bus.ram_clken) clk_low++;
      if (bus.ram_chipselect && bus.ram_clken) begin
        acc++;
        be_seen = bus.ram_byteenable;
      end
      if (bus.ram_write && bus.ram_clken && wr_at < 0) wr_at = n;
      if (bus.cpu_ack) begin
        acks++;
        if (lat < 0) begin
          lat = n; rd = bus.cpu_rdata; e = bus.cpu_err;
        end
        if (keep) drop = 1'b1;
        else bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_hold = 1'b0;
    bus.cpu_req = 1'b0;
  endtask
  int lat, acks, acc, clk_low, wr_at;
  logic [15:0] rd;
  logic e;
  logic [1:0] be_seen;
  task automatic test_reset();
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.cpu_ack); end
    checks++; if (bus.cpu_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.cpu_err); end
    checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus.cpu_rdata); end
    checks++; if (bus.ram_address !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.ram_address); end
    checks++; if (bus.ram_byteenable !== 2'b11) begin failures++; $display("FAIL reset_be got=%b exp=11", bus.ram_byteenable); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", bus.ram_chipselect); end
    checks++; if (bus.ram_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", bus.ram_write); end
    checks++; if (bus.ram_writedata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", bus.ram_writedata); end
    checks++; if (bus.ram_clken !== 1'b1) begin failures++; $display("FAIL reset_clken got=%b exp=1", bus.ram_clken); end
  endtask
  task automatic test_write_read();
    do_access(1'b1, wa(5), 1'b0, 16'hA55A, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (wr_at !== 1) begin failures++; $display("FAIL wr_write_cycle got=%0d exp=1", wr_at); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=2", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
    checks++; if (acks !== 1) begin failures++; $display("FAIL wr_acks got=%0d exp=1", acks); end
    do_access(1'b0, wa(5), 1'b0, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=3", lat); end
    checks++; if (rd !== 16'hA55A) begin failures++; $display("FAIL rd_data got=%h exp=a55a", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", e); end
    checks++; if (wr_at !== -1) begin failures++; $display("FAIL rd_no_write got=%0d exp=-1", wr_at); end
  endtask
  task automatic test_out_of_range();
    do_access(1'b0, wa(2048), 1'b0, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (lat !== 1) begin failures++; $display("FAIL oor_ack_cycle got=%0d exp=1", lat); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", e); end
    checks++; if (rd !== 16'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=0000", rd); end
    checks++; if (acc !== 0) begin failures++; $display("FAIL oor_cs got=%0d exp=0", acc); end
  endtask
  task automatic test_hold();
    do_access(1'b0, wa(5), 1'b0, 16'h0000, 2, 2, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (lat !== 5) begin failures++; $display("FAIL hold_ack_cycle got=%0d exp=5", lat); end
    checks++; if (rd !== 16'hA55A) begin failures++; $display("FAIL hold_data got=%h exp=a55a", rd); end
    checks++; if (clk_low !== 2) begin failures++; $display("FAIL hold_clken_low got=%0d exp=2", clk_low); end
    checks++; if (acks !== 1) begin failures++; $display("FAIL hold_acks got=%0d exp=1", acks); end
  endtask
  task automatic test_back_to_back();
    do_access(1'b1, wa(7), 1'b0, 16'h1234, 99, 0, 1'b1, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (acks !== 1) begin failures++; $display("FAIL keep_acks got=%0d exp=1", acks); end
    checks++; if (acc !== 1) begin failures++; $display("FAIL keep_accesses got=%0d exp=1", acc); end
    do_access(1'b0, wa(7), 1'b0, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL keep_readback got=%h exp=1234", rd); end
  endtask
  task automatic test_reset_mid();
    int n_ack;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = wa(5); bus.cpu_size = 1'b0;
    @(negedge clk);
    checks++; if (bus.ram_chipselect !== 1'b1) begin failures++; $display("FAIL rst_in_issue got=%b exp=1", bus.ram_chipselect); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=0000", bus.cpu_rdata); end
    checks++; if (bus.ram_address !== '0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0", bus.ram_address); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin failures++; $display("FAIL rst_mid_cs got=%b exp=0", bus.ram_chipselect); end
    checks++; if (bus.ram_writedata !== 16'h0) begin failures++; $display("FAIL rst_mid_wdata got=%h exp=0000", bus.ram_writedata); end
    checks++; if (bus.ram_clken !== 1'b1) begin failures++; $display("FAIL rst_mid_clken got=%b exp=1", bus.ram_clken); end
    reset = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) n_ack++;
    end
    checks++; if (n_ack !== 0) begin failures++; $display("FAIL rst_mid_no_ack got=%0d exp=0", n_ack); end
    do_access(1'b0, wa(5), 1'b0, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (lat !== 3 || rd !== 16'hA55A) begin failures++; $display("FAIL rst_recover got=%0d/%h exp=3/a55a", lat, rd); end
  endtask
`ifdef EP16_RAM_PORT_BYTE_EN
  task automatic test_byte_mode();
    do_access(1'b1, CAW'(11), 1'b1, 16'h003C, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (be_seen !== 2'b10) begin failures++; $display("FAIL byte_wr_be got=%b exp=10", be_seen); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL byte_wr_ack got=%0d exp=2", lat); end
    do_access(1'b0, wa(5), 1'b0, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (rd !== 16'h3C5A) begin failures++; $display("FAIL byte_word_rd got=%h exp=3c5a", rd); end
    do_access(1'b0, CAW'(11), 1'b1, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (rd !== 16'h003C) begin failures++; $display("FAIL byte_rd_hi got=%h exp=003c", rd); end
    do_access(1'b0, CAW'(10), 1'b1, 16'h0000, 99, 0, 1'b0, lat, acks, rd, e, acc, clk_low, wr_at, be_seen);
    checks++; if (rd !== 16'h005A) begin failures++; $display("FAIL byte_rd_lo got=%h exp=005a", rd); end
  endtask
`endif
  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_size = 1'b0;
    bus.cpu_wdata = '0; bus.cpu_hold = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef EP16_RAM_PORT_BYTE_EN
    test_byte_mode();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
